// File: rtl/aes_round_key_store_if.sv
// aes_round_key_store_if: control, key-generator and read-port signals of the AES round key store.
// AES_KEY_ZEROIZE_EN adds the zeroize request line.
interface aes_round_key_store_if #(
    parameter int KEY_W = 128
);
    logic             start;
    logic [KEY_W-1:0] cipher_key;
    logic             busy;
    logic             ready;
    logic [KEY_W-1:0] kg_key_out;
    logic [3:0]       kg_round;
    logic [KEY_W-1:0] kg_key_in;
    logic             rd_en;
    logic [3:0]       rd_round;
`ifdef AES_KEY_ZEROIZE_EN
    logic             zeroize;
`endif
    logic [KEY_W-1:0] rd_key;
    logic             rd_valid;
    logic             rd_err;

    modport master (
`ifdef AES_KEY_ZEROIZE_EN
        output zeroize,
`endif
        output start, cipher_key, kg_key_in, rd_en, rd_round,
        input  busy, ready, kg_key_out, kg_round, rd_key, rd_valid, rd_err
    );

    modport slave (
`ifdef AES_KEY_ZEROIZE_EN
        input  zeroize,
`endif
        input  start, cipher_key, kg_key_in, rd_en, rd_round,
        output busy, ready, kg_key_out, kg_round, rd_key, rd_valid, rd_err
    );
endinterface

// File: rtl/aes_round_key_store.sv
// aes_round_key_store: sequences the AES-128 key expansion stage and stores/serves all round keys.
// Optional AES_KEY_ZEROIZE_EN: zeroize input clears keys and forces IDLE.
module aes_round_key_store #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEYGEN_LAT = 2,
    parameter int KEY_W      = 128
) (
    input logic                  clk,
    input logic                  reset,
    aes_round_key_store_if.slave bus
);
    localparam int             LAT_W      = KEYGEN_LAT > 1 ? $clog2(KEYGEN_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(KEYGEN_LAT - 1);
    localparam logic [3:0]     LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DONE} state_t;

    state_t           state;
    logic [KEY_W-1:0] keys [0:NUM_ROUNDS];
    logic [3:0]       round_ctr;
    logic [LAT_W-1:0] lat_ctr;
    logic [3:0]       stored_count;
    logic             zero;
    logic             rd_hit;

`ifdef AES_KEY_ZEROIZE_EN
    assign zero = bus.zeroize;
`else
    assign zero = 1'b0;
`endif

    // stored_count only covers fully captured rounds, so a key being written this edge reads as missing
    assign rd_hit = bus.rd_en && (bus.rd_round <= LAST_ROUND) && (bus.rd_round < stored_count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.ready    <= 1'b0;
            bus.kg_key_out <= '0;
            bus.kg_round <= '0;
            round_ctr    <= '0;
            lat_ctr      <= '0;
            stored_count <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) keys[i] <= '0;
        end else if (zero) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.ready    <= 1'b0;
            bus.kg_key_out <= '0;
            stored_count <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) keys[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    keys[0]        <= bus.cipher_key;
                    bus.kg_key_out <= bus.cipher_key;
                    bus.kg_round   <= 4'd1;
                    round_ctr      <= 4'd1;
                    lat_ctr        <= '0;
                    stored_count   <= 4'd1;
                    bus.busy       <= 1'b1;
                    bus.ready      <= 1'b0;
                    state          <= WAIT;
                end
                WAIT: begin
                    lat_ctr <= lat_ctr + 1'b1;
                    if (lat_ctr == LAT_LAST) state <= CAPTURE;
                end
                CAPTURE: begin
                    keys[round_ctr] <= bus.kg_key_in;
                    bus.kg_key_out  <= bus.kg_key_in;
                    stored_count    <= round_ctr + 4'd1;
                    if (round_ctr == LAST_ROUND) begin
                        bus.busy  <= 1'b0;
                        bus.ready <= 1'b1;
                        state     <= DONE;
                    end else begin
                        round_ctr    <= round_ctr + 4'd1;
                        bus.kg_round <= bus.kg_round + 4'd1;
                        lat_ctr      <= '0;
                        state        <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rd_key   <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
        end else if (zero) begin
            bus.rd_key   <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
        end else begin
            bus.rd_valid <= rd_hit;
            bus.rd_err   <= bus.rd_en && !rd_hit;
            if (rd_hit) bus.rd_key <= keys[bus.rd_round];
        end
    end
endmodule

// File: tb/tb_aes_round_key_store.sv
// tb_aes_round_key_store: directed bench with a behavioural AES-128 key expansion stage (2-cycle latency).
// Build with AES_KEY_ZEROIZE_EN to also exercise zeroize.
module tb_aes_round_key_store;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [79:0] RCON = 80'h01020408102040801b36;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [127:0] exp_keys [0:10];
    logic [127:0] kg_p0, kg_p1;

    always #5 clk = ~clk;

    aes_round_key_store_if #(.KEY_W(128)) bus ();

    aes_round_key_store dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX[8*(255-int'(b)) +: 8];
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0] rc;
        rc = 8'h00;
        if (r >= 4'd1 && r <= 4'd10) rc = RCON[8*(10-int'(r)) +: 8];
        {w0, w1, w2, w3} = k;
        t = {w3[23:0], w3[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // expansion stage: result appears KEYGEN_LAT edges after its inputs settle
    always @(posedge clk) begin
        kg_p0 <= expand(bus.kg_key_out, bus.kg_round);
        kg_p1 <= kg_p0;
    end
    assign bus.kg_key_in = kg_p1;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [127:0] key);
        bus.start = 1'b1;
        bus.cipher_key = key;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] r);
        bus.rd_en = 1'b1;
        bus.rd_round = r;
        step(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic wait_ready(input int first_edge, output int ready_edge);
        ready_edge = -1;
        for (int n = first_edge; n <= 45; n++) begin
            step(1);
            if (bus.ready === 1'b1) begin
                ready_edge = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.cipher_key = '0;
        bus.rd_en = 1'b0;
        bus.rd_round = '0;
`ifdef AES_KEY_ZEROIZE_EN
        bus.zeroize = 1'b0;
`endif
        step(2);
        checks++;
        if ({bus.busy, bus.ready, bus.rd_valid, bus.rd_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.ready, bus.rd_valid, bus.rd_err});
        end
        checks++;
        if ({bus.kg_key_out, bus.kg_round, bus.rd_key} !== '0) begin
            errors++;
            $display("FAIL reset_data kg_key_out=%h kg_round=%0d rd_key=%h want 0", bus.kg_key_out, bus.kg_round, bus.rd_key);
        end
        reset = 1'b1;
        step(1);
        do_read(4'd0);
        checks++;
        if (bus.rd_err !== 1'b1 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_read err=%b valid=%b want 1 0", bus.rd_err, bus.rd_valid);
        end
    endtask

    task automatic test_expand;
        int ready_edge;
        pulse_start(FIPS_KEY);
        checks++;
        if (bus.busy !== 1'b1 || bus.kg_round !== 4'd1 || bus.kg_key_out !== FIPS_KEY) begin
            errors++;
            $display("FAIL start_seed busy=%b kg_round=%0d kg_key_out=%h", bus.busy, bus.kg_round, bus.kg_key_out);
        end
        // edge 0 samples start; ready appears in the 31st cycle counting the start cycle as 1
        wait_ready(1, ready_edge);
        checks++;
        if (ready_edge !== 30) begin
            errors++;
            $display("FAIL ready_latency got edge %0d want 30", ready_edge);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_busy got %b want 0", bus.busy);
        end
        for (int r = 0; r <= 10; r++) begin
            do_read(4'(r));
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b0 || bus.rd_key !== exp_keys[r]) begin
                errors++;
                $display("FAIL read_round%0d got %h v=%b e=%b want %h", r, bus.rd_key, bus.rd_valid, bus.rd_err, exp_keys[r]);
            end
        end
        do_read(4'd1);
        checks++;
        if (bus.rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++;
            $display("FAIL fips_round1 got %h want a0fafe1788542cb123a339392a6c7605", bus.rd_key);
        end
        do_read(4'd10);
        checks++;
        if (bus.rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL fips_round10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", bus.rd_key);
        end
        do_read(4'd0);
        checks++;
        if (bus.rd_key !== FIPS_KEY || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL fips_round0 got %h v=%b want %h 1", bus.rd_key, bus.rd_valid, FIPS_KEY);
        end
        step(1);
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_key !== FIPS_KEY) begin
            errors++;
            $display("FAIL valid_pulse v=%b key=%h want 0 and held key", bus.rd_valid, bus.rd_key);
        end
    endtask

    task automatic test_read_err_done;
        do_read(4'd11);
        checks++;
        if (bus.rd_err !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_key !== FIPS_KEY) begin
            errors++;
            $display("FAIL read_round11 e=%b v=%b key=%h want 1 0 held", bus.rd_err, bus.rd_valid, bus.rd_key);
        end
        do_read(4'd15);
        checks++;
        if (bus.rd_err !== 1'b1 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_round15 e=%b v=%b want 1 0", bus.rd_err, bus.rd_valid);
        end
        step(1);
        checks++;
        if (bus.rd_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse got %b want 0", bus.rd_err);
        end
    endtask

    task automatic test_busy_reads;
        int ready_edge;
        bus.rd_en = 1'b1;
        bus.rd_round = 4'd1;
        pulse_start(FIPS_KEY);
        bus.rd_en = 1'b0;
        checks++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b1 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL restart r=%b b=%b v=%b want 0 1 1", bus.ready, bus.busy, bus.rd_valid);
        end
        do_read(4'd1);
        checks++;
        if (bus.rd_err !== 1'b1 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_stale e=%b v=%b want 1 0", bus.rd_err, bus.rd_valid);
        end
        step(3);
        pulse_start(OTHER_KEY);
        checks++;
        if (bus.kg_round !== 4'd2 || bus.kg_key_out !== exp_keys[1] || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored kg_round=%0d kg_key_out=%h want 2 %h", bus.kg_round, bus.kg_key_out, exp_keys[1]);
        end
        step(4);
        do_read(4'd5);
        checks++;
        if (bus.rd_err !== 1'b1 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_round5 e=%b v=%b want 1 0", bus.rd_err, bus.rd_valid);
        end
        do_read(4'd2);
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_key !== exp_keys[2]) begin
            errors++;
            $display("FAIL busy_round2 v=%b got %h want %h", bus.rd_valid, bus.rd_key, exp_keys[2]);
        end
        do_read(4'd4);
        checks++;
        if (bus.rd_err !== 1'b1 || bus.rd_key !== exp_keys[2]) begin
            errors++;
            $display("FAIL capture_collide e=%b key=%h want 1 %h", bus.rd_err, bus.rd_key, exp_keys[2]);
        end
        do_read(4'd4);
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_key !== exp_keys[4]) begin
            errors++;
            $display("FAIL after_capture v=%b got %h want %h", bus.rd_valid, bus.rd_key, exp_keys[4]);
        end
        wait_ready(14, ready_edge);
        checks++;
        if (ready_edge !== 30) begin
            errors++;
            $display("FAIL ready_after_ignored got edge %0d want 30", ready_edge);
        end
        do_read(4'd10);
        checks++;
        if (bus.rd_key !== exp_keys[10]) begin
            errors++;
            $display("FAIL keys_unchanged got %h want %h", bus.rd_key, exp_keys[10]);
        end
    endtask

    task automatic test_reset_mid;
        pulse_start(FIPS_KEY);
        step(14);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.kg_round !== 4'd0) begin
            errors++;
            $display("FAIL async_reset b=%b r=%b kg_round=%0d want 0 0 0", bus.busy, bus.ready, bus.kg_round);
        end
        #1;
        reset = 1'b1;
        step(1);
        do_read(4'd1);
        checks++;
        if (bus.rd_err !== 1'b1 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_partial e=%b v=%b want 1 0", bus.rd_err, bus.rd_valid);
        end
        do_read(4'd0);
        checks++;
        if (bus.rd_err !== 1'b1 || bus.rd_key !== '0) begin
            errors++;
            $display("FAIL reset_round0 e=%b key=%h want 1 0", bus.rd_err, bus.rd_key);
        end
    endtask

`ifdef AES_KEY_ZEROIZE_EN
    task automatic test_zeroize;
        int ready_edge;
        pulse_start(FIPS_KEY);
        wait_ready(1, ready_edge);
        bus.zeroize = 1'b1;
        step(1);
        bus.zeroize = 1'b0;
        checks++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b0 || bus.kg_key_out !== '0) begin
            errors++;
            $display("FAIL zeroize_done r=%b b=%b kg=%h want 0 0 0", bus.ready, bus.busy, bus.kg_key_out);
        end
        do_read(4'd0);
        checks++;
        if (bus.rd_err !== 1'b1 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL zeroize_read e=%b v=%b want 1 0", bus.rd_err, bus.rd_valid);
        end
        bus.zeroize = 1'b1;
        pulse_start(FIPS_KEY);
        bus.zeroize = 1'b0;
        step(1);
        checks++;
        if (bus.busy !== 1'b0 || bus.kg_round === 4'd1 && bus.kg_key_out === FIPS_KEY) begin
            errors++;
            $display("FAIL zeroize_start b=%b kg=%h want idle", bus.busy, bus.kg_key_out);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        exp_keys[0] = FIPS_KEY;
        for (int r = 1; r <= 10; r++) exp_keys[r] = expand(exp_keys[r-1], 4'(r));
        test_reset();
        test_expand();
        test_read_err_done();
        test_busy_reads();
        test_reset_mid();
`ifdef AES_KEY_ZEROIZE_EN
        test_zeroize();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_round_key_store.md
Name: aes_round_key_store

Overview:
- Sequencer and storage stage directly downstream of the AES-128 key expansion stage.
- Seeds the expansion stage with the cipher key, then steps it through rounds 1..10, feeding each result back as the next input key.
- Captures all 11 round keys (round 0 = cipher key) into a register file.
- Serves round keys to the cipher datapath over a registered read port.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; keys 0..NUM_ROUNDS are stored.
- KEYGEN_LAT, 2, cycles from kg_key_out/kg_round being stable to kg_key_in being valid; must be >= 1.
- KEY_W, 128, round key width in bits.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state.
- start  in  1  pulse; begins expansion of cipher_key when idle or done.
- cipher_key  in  KEY_W  AES key, sampled with start. Byte 0 = bits[127:120], column-major per FIPS-197.
- busy  out  1  expansion in progress.
- ready  out  1  all NUM_ROUNDS+1 keys stored.
- kg_key_out  out  KEY_W  previous round key, driven to the expansion stage.
- kg_round  out  4  round number, driven to the expansion stage.
- kg_key_in  in  KEY_W  round key returned by the expansion stage.
- rd_en  in  1  read request.
- rd_round  in  4  round key index to read.
- rd_key  out  KEY_W  read data.
- rd_valid  out  1  rd_key valid, one-cycle pulse.
- rd_err  out  1  request targeted a missing round, one-cycle pulse.

Behaviour:
- Reset values: busy=0, ready=0, kg_key_out=0, kg_round=0, rd_key=0, rd_valid=0, rd_err=0. All stored keys = 0, stored_count=0, state=IDLE.
- States: IDLE, WAIT, CAPTURE, DONE.
- IDLE/DONE + start:
  - key[0] <= cipher_key; kg_key_out <= cipher_key.
  - kg_round <= 1; round_ctr <= 1; lat_ctr <= 0; stored_count <= 1.
  - busy <= 1; ready <= 0; go to WAIT.
- WAIT: lat_ctr increments each cycle. When lat_ctr == KEYGEN_LAT-1, go to CAPTURE. kg_key_out and kg_round are held stable throughout.
- CAPTURE:
  - key[round_ctr] <= kg_key_in; kg_key_out <= kg_key_in; stored_count <= round_ctr+1.
  - If round_ctr == NUM_ROUNDS: busy <= 0, ready <= 1, go to DONE.
  - Else: round_ctr++, kg_round++, lat_ctr <= 0, go to WAIT.
- Latency: ready rises exactly NUM_ROUNDS*(KEYGEN_LAT+1)+1 cycles after the start edge (31 with defaults).
- start while busy is ignored; the running expansion is unaffected.
- start in DONE restarts: ready drops next cycle and the old keys are unreadable until recaptured (stored_count reset to 1).
- Read port (independent of the FSM, one-cycle registered latency):
  - rd_en with rd_round < stored_count: next cycle rd_key = key[rd_round], rd_valid = 1.
  - Reads of already-captured rounds are permitted while busy.
  - rd_en with rd_round >= stored_count, or rd_round > NUM_ROUNDS: next cycle rd_valid = 0, rd_err = 1, rd_key holds its previous value.
  - Simultaneous CAPTURE and read of the same index returns the old contents and rd_err = 1, because stored_count updates after that edge.
- Reset mid-operation: immediate return to reset values; a partial key set is never readable.

Optional Feature:
- Macro: AES_KEY_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit, after rd_round).
  - zeroize=1 at a clock edge clears all stored keys, kg_key_out, rd_key and stored_count to 0; forces IDLE, busy=0, ready=0.
  - zeroize has priority over start and rd_en in the same cycle.
- Not defined: port absent; keys persist until overwritten by a new start or reset.

Test Plan:
- Defaults, behavioural key-expansion model with KEYGEN_LAT=2. start with cipher_key=2b7e151628aed2a6abf7158809cf4f3c -> ready=1 at cycle 31. Read round 1 -> a0fafe1788542cb123a339392a6c7605. Read round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Read round 0 after done -> 2b7e151628aed2a6abf7158809cf4f3c, rd_valid high for exactly 1 cycle.
- During expansion, read round 5 at cycle 10 -> rd_err=1, rd_valid=0. Read round 2 at cycle 10 -> rd_valid=1 with the correct key.
- Read rd_round=11 in DONE -> rd_err=1. Pulse start while busy at cycle 5 -> ignored, ready still at cycle 31, keys unchanged.
- Drive reset low at cycle 15 -> busy=0, ready=0 immediately. Read round 1 after release -> rd_err=1.
- With AES_KEY_ZEROIZE_EN: zeroize in DONE -> ready=0, read round 0 -> rd_err=1. Zeroize and start in the same cycle -> state IDLE, busy=0.
